fec_decode_sched: RTL and testbench



---
 rtl/fec_decode_sched.sv | 177 +++++++++++++++++
 tb/tb_fec_decode_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fec_decode_sched.sv
// Round-robin scheduler sharing one Hamming decoder among NUM_REQ lanes, one job in flight.
// Optional per-lane corrected-error counters: define FEC_ERRCNT_EN.
module fec_decode_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LANE_W  = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [8*NUM_REQ-1:0]  req_cw,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  dec_start,
  output logic [7:0]            dec_cw,
  input  logic                  dec_done,
  input  logic [3:0]            dec_data,
  input  logic [2:0]            dec_syn,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_data,
  output logic [LANE_W-1:0]     out_lane,
  output logic                  out_corr,
  output logic                  busy,
  output logic                  timeout_err
`ifdef FEC_ERRCNT_EN
  ,
  input  logic [LANE_W-1:0]     err_sel,
  output logic [7:0]            err_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUTPUT} state_t;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   ptr_q, ptr_d;
  logic [7:0]          cw_q, cw_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [3:0]          data_q, data_d;
  logic                corr_q, corr_d;
  logic [7:0]          timer_q, timer_d;
  logic                start_q, start_d;
  logic                tmo_q, tmo_d;

  logic                gnt_found;
  logic [LANE_W-1:0]   gnt_idx;
  logic [LANE_W-1:0]   cand;
  logic [7:0]          cw_sel;
  int unsigned         idx;

  // First valid lane searching upward from ptr+1, wrapping at NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = 32'(ptr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = LANE_W'(idx);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    cw_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == LANE_W'(i)) cw_sel = req_cw[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cw_d      = cw_q;
    lane_d    = lane_q;
    data_d    = data_q;
    corr_d    = corr_q;
    timer_d   = timer_q;
    start_d   = 1'b0;
    tmo_d     = 1'b0;
    req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found && !reset) begin
          req_ready = NUM_REQ'(1) << gnt_idx;
          cw_d      = cw_sel;
          lane_d    = gnt_idx;
          ptr_d     = gnt_idx;
          start_d   = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 8'd1;
        if (dec_done) begin
          data_d  = dec_data;
          corr_d  = |dec_syn;
          state_d = S_OUTPUT;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          // Exit one cycle early so the registered pulse lands TIMEOUT+1 after dec_start.
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_OUTPUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= LANE_W'(NUM_REQ - 1);
      cw_q    <= '0;
      lane_q  <= '0;
      data_q  <= '0;
      corr_q  <= 1'b0;
      timer_q <= '0;
      start_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cw_q    <= cw_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      corr_q  <= corr_d;
      timer_q <= timer_d;
      start_q <= start_d;
      tmo_q   <= tmo_d;
    end
  end

  assign dec_start   = start_q;
  assign dec_cw      = cw_q;
  assign out_valid   = (state_q == S_OUTPUT);
  assign out_data    = data_q;
  assign out_lane    = lane_q;
  assign out_corr    = corr_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = tmo_q;

`ifdef FEC_ERRCNT_EN
  logic [7:0] cnt_q [NUM_REQ];
  logic       cnt_inc;

  assign cnt_inc = (state_q == S_WAIT) && dec_done && (|dec_syn);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (cnt_inc && lane_q == LANE_W'(i) && cnt_q[i] != 8'hFF)
          cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end
  end

  always_comb begin
    err_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (err_sel == LANE_W'(i)) err_cnt = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_fec_decode_sched.sv
// Directed bench for fec_decode_sched: decoder mock, grant log and result scoreboard.
module tb_fec_decode_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_cw;
  logic [3:0]  req_ready;
  logic        dec_start;
  logic [7:0]  dec_cw;
  logic        dec_done;
  logic [3:0]  dec_data;
  logic [2:0]  dec_syn;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_lane;
  logic        out_corr;
  logic        busy;
  logic        timeout_err;
`ifdef FEC_ERRCNT_EN
  logic [1:0]  err_sel;
  logic [7:0]  err_cnt;
`endif

  fec_decode_sched #(.NUM_REQ(4), .LANE_W(2), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_cw(req_cw), .req_ready(req_ready),
    .dec_start(dec_start), .dec_cw(dec_cw),
    .dec_done(dec_done), .dec_data(dec_data), .dec_syn(dec_syn),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lane(out_lane), .out_corr(out_corr),
    .busy(busy), .timeout_err(timeout_err)
`ifdef FEC_ERRCNT_EN
    , .err_sel(err_sel), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decoder mock: data is a fixed function of the codeword, syndrome is chosen by the bench.
  function automatic logic [3:0] mock_fn(input logic [7:0] cw);
    return cw[7:4] ^ cw[3:0] ^ 4'hC;
  endfunction

  logic       mock_en = 1'b1;
  int         mock_delay = 2;
  logic [2:0] mock_syn = 3'b000;
  logic       mock_done, stray_done;
  logic [7:0] cw_l;
  assign dec_done = mock_done | stray_done;

  initial begin
    mock_done = 1'b0; dec_data = '0; dec_syn = '0;
    forever begin
      @(posedge clk); #1;
      if (dec_start && mock_en) begin
        cw_l = dec_cw;
        repeat (mock_delay) @(posedge clk);
        #1;
        mock_done = 1'b1; dec_data = mock_fn(cw_l); dec_syn = mock_syn;
        @(posedge clk); #1;
        mock_done = 1'b0; dec_data = '0; dec_syn = '0;
      end
    end
  end

  // Grant log and scoreboard push at accept; pop and compare at output handshake.
  logic [6:0] sbq[$];
  int         glane[$];
  int         gtime[$];
  int         gcount = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        glane.push_back(i);
        gtime.push_back(cyc_cnt);
        gcount++;
        if (mock_en) sbq.push_back({|mock_syn, 2'(i), mock_fn(req_cw[8*i +: 8])});
      end
    end
  end

  logic [6:0] exp_r;
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sbq.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
      else begin
        exp_r = sbq.pop_front();
        chk("result", {25'd0, out_corr, out_lane, out_data}, {25'd0, exp_r});
      end
    end
  end

  task automatic tick; @(posedge clk); #1; endtask
  task automatic ck_pt; @(negedge clk); #1; endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 100; i++) begin
      ck_pt();
      if (!busy && sbq.size() == 0) break;
    end
    chk(tag, {31'd0, i < 100}, 32'd1);
    tick();
  endtask

  task automatic wait_grants(input int target, input int budget, input string tag);
    int i;
    for (i = 0; i < budget && gcount < target; i++) ck_pt();
    chk(tag, {31'd0, gcount >= target}, 32'd1);
  endtask

  task automatic do_reset;
    tick(); reset = 1'b1; req_valid = '0;
    tick(); tick(); reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int t0, tt, g0;
  logic ov_seen;
  logic [3:0] d0;

  initial begin
    reset = 1'b1; req_valid = '0; out_ready = 1'b1; stray_done = 1'b0;
    req_cw = {8'hC7, 8'h3A, 8'h92, 8'h61};
`ifdef FEC_ERRCNT_EN
    err_sel = 2'd1;
`endif
    tick(); tick(); ck_pt();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dec_start", {31'd0, dec_start}, 32'd0);
    chk("rst_dec_cw", {24'd0, dec_cw}, 32'd0);
    chk("rst_outs", {24'd0, out_data, out_lane, out_corr, timeout_err}, 32'd0);
    tick(); reset = 1'b0;

    // Single lane, decoder answers 2 cycles after start
    mock_delay = 2; mock_syn = 3'b000;
    tick(); req_valid = 4'b0100; ck_pt();
    chk("single_ready", {28'd0, req_ready}, 32'h4);
    tick(); req_valid = '0; ck_pt();
    chk("single_start", {31'd0, dec_start}, 32'd1);
    chk("single_cw", {24'd0, dec_cw}, 32'h3A);
    tick(); ck_pt();
    chk("start_pulse_len", {31'd0, dec_start}, 32'd0);
    chk("busy_wait", {31'd0, busy}, 32'd1);
    tick(); ck_pt();
    chk("no_early_valid", {31'd0, out_valid}, 32'd0);
    tick(); ck_pt();
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_res", {25'd0, out_corr, out_lane, out_data}, {25'd0, 1'b0, 2'd2, 4'h5});
    wait_idle("single_idle");

    // Fairness with all lanes valid, minimum decoder latency
    do_reset();
    mock_delay = 1; g0 = gcount;
    req_valid = 4'b1111;
    wait_grants(g0 + 6, 100, "fair_grants");
    req_valid = 4'b1010;  // lane skipping continues from last grant to lane 1
    for (int k = 0; k < 6; k++) chk("fair_order", glane[g0 + k], (k % 4));
    chk("turnaround", gtime[g0 + 1] - gtime[g0], 32'd4);
    wait_grants(g0 + 8, 100, "skip_grants");
    tick(); req_valid = '0;
    chk("skip_first", glane[g0 + 6], 32'd3);
    chk("skip_second", glane[g0 + 7], 32'd1);
    wait_idle("fair_idle");

    // Timeout: decoder silent
    mock_en = 1'b0; ov_seen = 1'b0;
    tick(); req_valid = 4'b0001; ck_pt();
    chk("tmo_ready", {28'd0, req_ready}, 32'h1);
    tick(); req_valid = '0; ck_pt();
    chk("tmo_start", {31'd0, dec_start}, 32'd1);
    t0 = cyc_cnt;
    for (tt = 0; tt < 40; tt++) begin
      tick(); ck_pt();
      if (out_valid) ov_seen = 1'b1;
      if (timeout_err) break;
    end
    chk("tmo_delay", cyc_cnt - t0, 32'd16);
    chk("tmo_no_valid", {31'd0, ov_seen}, 32'd0);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    mock_en = 1'b1; mock_delay = 1;
    tick(); req_valid = 4'b0100; ck_pt();
    chk("tmo_pulse_len", {31'd0, timeout_err}, 32'd0);
    chk("tmo_next_grant", {28'd0, req_ready}, 32'h4);
    tick(); req_valid = '0;
    wait_idle("tmo_idle");

    // Done on the last allowed cycle must win over the timeout
    mock_delay = 15; ov_seen = 1'b0;
    tick(); req_valid = 4'b1000;
    tick(); req_valid = '0;
    for (int k = 0; k < 25; k++) begin ck_pt(); if (timeout_err) ov_seen = 1'b1; end
    chk("late_done_no_tmo", {31'd0, ov_seen}, 32'd0);
    wait_idle("late_idle");

    // Backpressure with stray dec_done in OUTPUT and a competing request
    mock_delay = 1; mock_syn = 3'b010; out_ready = 1'b0;
    tick(); req_valid = 4'b0001;
    tick(); req_valid = 4'b0010;
    for (tt = 0; tt < 20; tt++) begin ck_pt(); if (out_valid) break; end
    chk("bp_reached", {31'd0, out_valid}, 32'd1);
    d0 = mock_fn(8'h61);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) ck_pt();
      chk("bp_hold", {24'd0, out_valid, out_corr, out_lane, out_data}, {24'd0, 1'b1, 1'b1, 2'd0, d0});
      chk("bp_no_grant", {28'd0, req_ready}, 32'd0);
      tick(); stray_done = (k == 1);
    end
    out_ready = 1'b1; req_valid = '0; stray_done = 1'b0;
    wait_idle("bp_idle");

    // Reset in the middle of WAIT
    mock_en = 1'b0; mock_syn = 3'b000;
    tick(); req_valid = 4'b1000;
    tick(); req_valid = '0;
    tick(); tick(); reset = 1'b1; req_valid = 4'b1111;
    tick(); ck_pt();
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_outs", {24'd0, out_valid, dec_start, out_data, timeout_err, out_corr}, 32'd0);
    chk("mid_rst_cw", {24'd0, dec_cw}, 32'd0);
    chk("mid_rst_ready", {28'd0, req_ready}, 32'd0);
    tick(); reset = 1'b0; mock_en = 1'b1; ck_pt();
    chk("post_rst_grant", {28'd0, req_ready}, 32'h1);
    tick(); req_valid = '0;
    wait_idle("post_rst_idle");

`ifdef FEC_ERRCNT_EN
    do_reset();
    mock_syn = 3'b110; err_sel = 2'd1; g0 = gcount;
    req_valid = 4'b0010;
    wait_grants(g0 + 3, 60, "cnt_grants3");
    tick(); req_valid = '0;
    wait_idle("cnt_idle3");
    ck_pt();
    chk("err_cnt_3", {24'd0, err_cnt}, 32'd3);
    err_sel = 2'd0; ck_pt();
    chk("err_cnt_lane0", {24'd0, err_cnt}, 32'd0);
    err_sel = 2'd1;
    tick(); req_valid = 4'b0010;
    wait_grants(g0 + 300, 1400, "cnt_grants300");
    tick(); req_valid = '0;
    wait_idle("cnt_idle300");
    ck_pt();
    chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
`endif

    chk("sb_drained", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
